// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
package mips_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'd2;
    localparam logic [ALU_W-1:0] ALU_SRL = 3'd3;
    localparam logic [ALU_W-1:0] ALU_SLL = 3'd4;
    localparam logic [ALU_W-1:0] ALU_XOR = 3'd5;
    localparam logic [ALU_W-1:0] ALU_AND = 3'd6;
    localparam logic [ALU_W-1:0] ALU_SRA = 3'd7;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
    localparam logic [OP_W-1:0] FN_SRL  = 6'h02;
    localparam logic [OP_W-1:0] FN_SRAV = 6'h07;
    localparam logic [OP_W-1:0] FN_JR   = 6'h08;
    localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
    localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
    localparam logic [OP_W-1:0] FN_AND  = 6'h24;
    localparam logic [OP_W-1:0] FN_OR   = 6'h25;
    localparam logic [OP_W-1:0] FN_XOR  = 6'h26;

    localparam logic [SEL_W-1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [SEL_W-1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [SEL_W-1:0] PC_SRC_RS     = 2'd3;

    localparam logic [SEL_W-1:0] REG_DST_RT = 2'd0;
    localparam logic [SEL_W-1:0] REG_DST_RD = 2'd1;
    localparam logic [SEL_W-1:0] REG_DST_RA = 2'd2;

    localparam logic [SEL_W-1:0] WB_ALU = 2'd0;
    localparam logic [SEL_W-1:0] WB_MEM = 2'd1;
    localparam logic [SEL_W-1:0] WB_PC  = 2'd2;

    localparam logic [SEL_W-1:0] ALUB_RT   = 2'd0;
    localparam logic [SEL_W-1:0] ALUB_IMM  = 2'd1;
    localparam logic [SEL_W-1:0] ALUB_FOUR = 2'd2;

    localparam logic [SEL_W-1:0] EXT_ZERO = 2'd0;
    localparam logic [SEL_W-1:0] EXT_SIGN = 2'd1;
    localparam logic [SEL_W-1:0] EXT_LUI  = 2'd2;

    typedef enum logic [3:0] {
        C_ILLEGAL = 4'd0,
        C_RTYPE   = 4'd1,
        C_JR      = 4'd2,
        C_ORI     = 4'd3,
        C_LUI     = 4'd4,
        C_LW      = 4'd5,
        C_SW      = 4'd6,
        C_BEQ     = 4'd7,
        C_J       = 4'd8,
        C_JAL     = 4'd9
    } iclass_t;

    typedef struct packed {
        logic             pc_write;
        logic [SEL_W-1:0] pc_src;
        logic             ir_write;
        logic             mem_write;
        logic             reg_write;
        logic [SEL_W-1:0] reg_dst;
        logic [SEL_W-1:0] mem_to_reg;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] ext_op;
        logic [ALU_W-1:0] alu_ctrl;
        logic             retire;
        logic             illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Instruction classification and per-state control template.
module mc_ctrl_decode
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    input  logic [OP_W-1:0]  funct,
    input  state_t           state,
    input  logic             zero,
    output iclass_t          iclass,
    output logic [ALU_W-1:0] alu_r,
    output logic             legal,
    output ctrl_t            tmpl
);

    // Map opcode/funct to an instruction class and R-type ALU op
    always_comb begin
        iclass = C_ILLEGAL;
        alu_r  = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: begin iclass = C_RTYPE; alu_r = ALU_ADD; end
                    FN_SUBU: begin iclass = C_RTYPE; alu_r = ALU_SUB; end
                    FN_AND:  begin iclass = C_RTYPE; alu_r = ALU_AND; end
                    FN_OR:   begin iclass = C_RTYPE; alu_r = ALU_OR;  end
                    FN_XOR:  begin iclass = C_RTYPE; alu_r = ALU_XOR; end
                    FN_SLL:  begin iclass = C_RTYPE; alu_r = ALU_SLL; end
                    FN_SRL:  begin iclass = C_RTYPE; alu_r = ALU_SRL; end
                    FN_SRAV: begin iclass = C_RTYPE; alu_r = ALU_SRA; end
                    FN_JR:   iclass = C_JR;
                    default: iclass = C_ILLEGAL;
                endcase
            end
            OP_ORI:  iclass = C_ORI;
            OP_LUI:  iclass = C_LUI;
            OP_LW:   iclass = C_LW;
            OP_SW:   iclass = C_SW;
            OP_BEQ:  iclass = C_BEQ;
            OP_J:    iclass = C_J;
            OP_JAL:  iclass = C_JAL;
            default: iclass = C_ILLEGAL;
        endcase
        legal = (iclass != C_ILLEGAL);
    end

    // Control outputs for the current state and instruction class
    always_comb begin
        tmpl = '0;
        case (state)
            S_FETCH: begin
                tmpl.ir_write  = 1'b1;
                tmpl.pc_write  = 1'b1;
                tmpl.pc_src    = PC_SRC_PC4;
                tmpl.alu_src_b = ALUB_FOUR;
                tmpl.alu_ctrl  = ALU_ADD;
            end
            S_DECODE: begin
                case (iclass)
                    C_J: begin
                        tmpl.pc_write = 1'b1;
                        tmpl.pc_src   = PC_SRC_JUMP;
                        tmpl.retire   = 1'b1;
                    end
                    C_JR: begin
                        tmpl.pc_write = 1'b1;
                        tmpl.pc_src   = PC_SRC_RS;
                        tmpl.retire   = 1'b1;
                    end
                    C_JAL: begin
                        tmpl.pc_write   = 1'b1;
                        tmpl.pc_src     = PC_SRC_JUMP;
                        tmpl.reg_write  = 1'b1;
                        tmpl.reg_dst    = REG_DST_RA;
                        tmpl.mem_to_reg = WB_PC;
                        tmpl.retire     = 1'b1;
                    end
                    C_ILLEGAL: tmpl.illegal = 1'b1;
                    default: ;
                endcase
            end
            S_EXEC: begin
                case (iclass)
                    C_RTYPE: begin
                        tmpl.alu_src_b = ALUB_RT;
                        tmpl.alu_ctrl  = alu_r;
                    end
                    C_ORI: begin
                        tmpl.alu_src_b = ALUB_IMM;
                        tmpl.ext_op    = EXT_ZERO;
                        tmpl.alu_ctrl  = ALU_OR;
                    end
                    C_LUI: begin
                        tmpl.alu_src_b = ALUB_IMM;
                        tmpl.ext_op    = EXT_LUI;
                        tmpl.alu_ctrl  = ALU_OR;
                    end
                    C_LW, C_SW: begin
                        tmpl.alu_src_b = ALUB_IMM;
                        tmpl.ext_op    = EXT_SIGN;
                        tmpl.alu_ctrl  = ALU_ADD;
                    end
                    C_BEQ: begin
                        tmpl.alu_ctrl = ALU_SUB;
                        tmpl.pc_write = zero;
                        tmpl.pc_src   = PC_SRC_BRANCH;
                        tmpl.retire   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (iclass == C_SW) begin
                    tmpl.mem_write = 1'b1;
                    tmpl.retire    = 1'b1;
                end
            end
            S_WB: begin
                tmpl.reg_write  = 1'b1;
                tmpl.retire     = 1'b1;
                tmpl.reg_dst    = (iclass == C_RTYPE) ? REG_DST_RD : REG_DST_RT;
                tmpl.mem_to_reg = (iclass == C_LW) ? WB_MEM : WB_ALU;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register, sequencing and output gating.
module mc_ctrl
    import mips_pkg::*;
#(
    parameter logic [STATE_W-1:0] RESET_STATE = 3'd0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic               zero,
    output logic               pc_write,
    output logic [SEL_W-1:0]   pc_src,
    output logic               ir_write,
    output logic               mem_write,
    output logic               reg_write,
    output logic [SEL_W-1:0]   reg_dst,
    output logic [SEL_W-1:0]   mem_to_reg,
    output logic [SEL_W-1:0]   alu_src_b,
    output logic [SEL_W-1:0]   ext_op,
    output logic [ALU_W-1:0]   alu_ctrl,
    output logic [STATE_W-1:0] state,
    output logic               retire,
    output logic               illegal
);

    state_t           state_q;
    state_t           state_d;
    iclass_t          iclass;
    logic [ALU_W-1:0] alu_r;
    logic             legal;
    ctrl_t            tmpl;
    ctrl_t            ctrl;
    logic             unused_instr_bits;

    assign unused_instr_bits = ^instr[25:6];

    mc_ctrl_decode u_decode (
        .op     (instr[31:26]),
        .funct  (instr[5:0]),
        .state  (state_q),
        .zero   (zero),
        .iclass (iclass),
        .alu_r  (alu_r),
        .legal  (legal),
        .tmpl   (tmpl)
    );

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: skip states the current instruction does not need
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (!legal || iclass == C_J || iclass == C_JR || iclass == C_JAL)
                                ? S_FETCH : S_EXEC;
            S_EXEC: begin
                if (iclass == C_BEQ)                        state_d = S_FETCH;
                else if (iclass == C_LW || iclass == C_SW)  state_d = S_MEM;
                else                                        state_d = S_WB;
            end
            S_MEM:    state_d = (iclass == C_LW) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Reset suppresses every write in the cycle it is asserted
    assign ctrl       = reset ? ctrl_t'('0) : tmpl;
    assign state      = reset ? STATE_W'(0) : state_q;
    assign pc_write   = ctrl.pc_write;
    assign pc_src     = ctrl.pc_src;
    assign ir_write   = ctrl.ir_write;
    assign mem_write  = ctrl.mem_write;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_b  = ctrl.alu_src_b;
    assign ext_op     = ctrl.ext_op;
    assign alu_ctrl   = ctrl.alu_ctrl;
    assign retire     = ctrl.retire;
    assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl against an instruction-level reference model.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        pc_write, ir_write, mem_write, reg_write, retire, illegal;
    logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b, ext_op;
    logic [2:0]  alu_ctrl, state;

    int errors = 0;
    int checks = 0;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .zero       (zero),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .alu_ctrl   (alu_ctrl),
        .state      (state),
        .retire     (retire),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observed outputs as one vector
    function automatic logic [31:0] observed();
        return 32'({pc_write, pc_src, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
                    alu_src_b, ext_op, alu_ctrl, retire, illegal, state});
    endfunction

    function automatic string mnem(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        case (op)
            6'h00: case (fn)
                6'h21: return "addu";
                6'h23: return "subu";
                6'h24: return "and";
                6'h25: return "or";
                6'h26: return "xor";
                6'h00: return "sll";
                6'h02: return "srl";
                6'h07: return "srav";
                6'h08: return "jr";
                default: return "ill";
            endcase
            6'h0D: return "ori";
            6'h0F: return "lui";
            6'h23: return "lw";
            6'h2B: return "sw";
            6'h04: return "beq";
            6'h02: return "j";
            6'h03: return "jal";
            default: return "ill";
        endcase
    endfunction

    function automatic int n_cycles(input string m);
        if (m == "j" || m == "jr" || m == "jal" || m == "ill") return 2;
        if (m == "beq") return 3;
        if (m == "lw") return 5;
        return 4;
    endfunction

    // ALU op for R-type arithmetic; -1 flags a non-ALU R-type
    function automatic int alu_of(input string m);
        case (m)
            "addu": return 0;
            "subu": return 1;
            "or":   return 2;
            "srl":  return 3;
            "sll":  return 4;
            "xor":  return 5;
            "and":  return 6;
            "srav": return 7;
            default: return -1;
        endcase
    endfunction

    // Expected output vector for cycle k of instruction m
    function automatic logic [31:0] model(input string m, input int k, input logic z);
        logic       pw, irw, mw, rw, ret, ill;
        logic [1:0] ps, rd, mtr, asb, ext;
        logic [2:0] alu, st;
        int         n;
        n = n_cycles(m);
        {pw, irw, mw, rw, ret, ill} = '0;
        {ps, rd, mtr, asb, ext} = '0;
        alu = 3'd0;
        if (k < 3)       st = 3'(k);
        else if (k == 3) st = (m == "lw" || m == "sw") ? 3'd3 : 3'd4;
        else             st = 3'd4;
        if (k == 0) begin
            irw = 1'b1; pw = 1'b1; asb = 2'd2;
        end else if (k == 1) begin
            if (m == "j")   begin pw = 1'b1; ps = 2'd2; end
            if (m == "jr")  begin pw = 1'b1; ps = 2'd3; end
            if (m == "jal") begin pw = 1'b1; ps = 2'd2; rw = 1'b1; rd = 2'd2; mtr = 2'd2; end
            if (m == "ill") ill = 1'b1;
        end else if (st == 3'd2) begin
            if (m == "beq") begin alu = 3'd1; pw = z; ps = 2'd1; end
            else if (m == "ori") begin asb = 2'd1; ext = 2'd0; alu = 3'd2; end
            else if (m == "lui") begin asb = 2'd1; ext = 2'd2; alu = 3'd2; end
            else if (m == "lw" || m == "sw") begin asb = 2'd1; ext = 2'd1; alu = 3'd0; end
            else alu = 3'(alu_of(m));
        end else if (st == 3'd3) begin
            if (m == "sw") mw = 1'b1;
        end else begin
            rw  = 1'b1;
            rd  = (alu_of(m) >= 0) ? 2'd1 : 2'd0;
            mtr = (m == "lw") ? 2'd1 : 2'd0;
        end
        ret = (k == n - 1) && (m != "ill");
        return 32'({pw, ps, irw, mw, rw, rd, mtr, asb, ext, alu, ret, ill, st});
    endfunction

    // Run one instruction from S_FETCH; reset is raised at step rst_at if in range
    task automatic run_instr(input logic [31:0] w, input logic z, input int rst_at);
        string m;
        int    n;
        m = mnem(w);
        n = n_cycles(m);
        instr = w;
        zero  = z;
        for (int k = 0; k < n; k++) begin
            if (k == rst_at) reset = 1'b1;
            @(negedge clk);
            if (k == rst_at) begin
                check_eq($sformatf("%s rst k%0d", m, k), observed(), 32'h0);
                @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            check_eq($sformatf("%s %h k%0d", m, w, k), observed(), model(m, k, z));
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 19);
        if (sel <= 9) begin
            w[31:26] = 6'h00;
            case (sel)
                0: w[5:0] = 6'h21;
                1: w[5:0] = 6'h23;
                2: w[5:0] = 6'h24;
                3: w[5:0] = 6'h25;
                4: w[5:0] = 6'h26;
                5: w[5:0] = 6'h00;
                6: w[5:0] = 6'h02;
                7: w[5:0] = 6'h07;
                8: w[5:0] = 6'h08;
                default: ;
            endcase
        end else if (sel <= 16) begin
            case (sel)
                10: w[31:26] = 6'h0D;
                11: w[31:26] = 6'h0F;
                12: w[31:26] = 6'h23;
                13: w[31:26] = 6'h2B;
                14: w[31:26] = 6'h04;
                15: w[31:26] = 6'h02;
                default: w[31:26] = 6'h03;
            endcase
        end
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        int          rst_at;
        reset = 1'b1;
        instr = 32'h00221821;
        repeat (3) begin
            @(negedge clk);
            check_eq("reset hold", observed(), 32'h0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(32'h00221821, 1'b0, -1);
        run_instr(32'h8C220004, 1'b0, -1);
        run_instr(32'hAC220004, 1'b1, -1);
        run_instr(32'h10220003, 1'b1, -1);
        run_instr(32'h10220003, 1'b0, -1);
        run_instr(32'h0C000010, 1'b0, -1);
        run_instr(32'hFC000000, 1'b0, -1);
        run_instr(32'h0000003F, 1'b0, -1);
        run_instr(32'h00011007, 1'b0, -1);
        run_instr(32'hAC220004, 1'b0, 3);
        run_instr(32'h00221821, 1'b0, -1);

        for (int i = 0; i < 400; i++) begin
            w      = rand_instr();
            rst_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(w, 1'($urandom), rst_at);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
